// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder standing in for the backing store of a direct-mapped
//   cache. Accepts one read or write request at a time, waits a fixed number of
//   cycles to model memory latency, then returns read data or a write
//   acknowledge and holds it until the requester takes it.
//
// Parameters
//   ADDR_W   word address width; storage depth is 2**ADDR_W words
//   DATA_W   word width
//   LATENCY  cycles from request accept edge to rsp_valid (1..15)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   req_valid  request present
//   req_ready  responder can accept a request (IDLE only)
//   req_addr   word address, sampled on the accept edge
//   req_w_r    1 = write, 0 = read, sampled on the accept edge
//   req_data   write data, sampled on the accept edge
//   rsp_valid  response present (RESP only)
//   rsp_ready  requester accepts the response
//   rsp_data   read data; 0 for write acks
//   rsp_w_r    direction of the transaction being answered
//   busy       high while a transaction is in flight (WAIT or RESP)
module mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_w_r,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_w_r,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter is loaded with LATENCY-1 on accept; the edge on which it reads
    // zero is the LATENCY-th edge after accept and produces the response.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] data_q, data_nxt;
    logic              w_r_q, w_r_nxt;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_nxt;
    logic              rsp_w_r_q, rsp_w_r_nxt;
    logic              mem_we;

    // Backing store; deliberately outside the reset domain so contents
    // survive rst.
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            w_r_q      <= 1'b0;
            rsp_data_q <= '0;
            rsp_w_r_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            addr_q     <= addr_nxt;
            data_q     <= data_nxt;
            w_r_q      <= w_r_nxt;
            rsp_data_q <= rsp_data_nxt;
            rsp_w_r_q  <= rsp_w_r_nxt;
        end
    end

    // mem_we is only ever high in WAIT, so an asynchronous reset that drops
    // the FSM to IDLE before the commit edge also cancels the write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= data_q;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        addr_nxt     = addr_q;
        data_nxt     = data_q;
        w_r_nxt      = w_r_q;
        rsp_data_nxt = rsp_data_q;
        rsp_w_r_nxt  = rsp_w_r_q;
        mem_we       = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    addr_nxt  = req_addr;
                    data_nxt  = req_data;
                    w_r_nxt   = req_w_r;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = WAIT;
                end
            end

            WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    if (w_r_q) begin
                        mem_we       = 1'b1;
                        rsp_data_nxt = '0;
                    end else begin
                        rsp_data_nxt = mem[addr_q];
                    end
                    rsp_w_r_nxt = w_r_q;
                    state_nxt   = RESP;
                end
            end

            RESP: begin
                // rsp_w_r is left as is after the handshake; only data clears.
                if (rsp_ready) begin
                    rsp_data_nxt = '0;
                    state_nxt    = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign rsp_data  = rsp_data_q;
    assign rsp_w_r   = rsp_w_r_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Directed bench for mem_responder. Two instances: dut (LATENCY=3) and
//   dut1 (LATENCY=1). A transaction-level model per instance predicts every
//   output each cycle; directed sequences add literal expectations.
module tb_mem_responder;

    localparam int LAT0 = 3;
    localparam int LAT1 = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_addr  = 8'h00;
    logic       req_w_r   = 1'b0;
    logic [7:0] req_data  = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_w_r;
    logic       busy;

    logic       req_valid1 = 1'b0;
    logic       req_ready1;
    logic [7:0] req_addr1  = 8'h00;
    logic       req_w_r1   = 1'b0;
    logic [7:0] req_data1  = 8'h00;
    logic       rsp_valid1;
    logic       rsp_ready1 = 1'b0;
    logic [7:0] rsp_data1;
    logic       rsp_w_r1;
    logic       busy1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .DATA_W(8), .LATENCY(LAT0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_w_r(req_w_r), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_w_r(rsp_w_r), .busy(busy)
    );

    mem_responder #(.ADDR_W(8), .DATA_W(8), .LATENCY(LAT1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
        .req_w_r(req_w_r1), .req_data(req_data1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1),
        .rsp_w_r(rsp_w_r1), .busy(busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic       m_pend [2] = '{1'b0, 1'b0};
    logic       m_resp [2] = '{1'b0, 1'b0};
    logic [7:0] ma     [2] = '{8'h00, 8'h00};
    logic [7:0] md     [2] = '{8'h00, 8'h00};
    logic       mw     [2] = '{1'b0, 1'b0};
    int         age    [2] = '{0, 0};
    logic [7:0] ed     [2] = '{8'h00, 8'h00};
    logic       ew     [2] = '{1'b0, 1'b0};
    logic [7:0] shadow [2][256];

    // One edge of a serialized memory: accept when free, respond LATENCY
    // edges later, release when the response is taken.
    task automatic model_step(input int k, input int lat, input logic v,
                              input logic [7:0] a, input logic [7:0] d,
                              input logic w, input logic rr);
        if (!m_pend[k]) begin
            if (v) begin
                m_pend[k] = 1'b1;
                ma[k] = a;
                md[k] = d;
                mw[k] = w;
                age[k] = 0;
            end
        end else if (!m_resp[k]) begin
            age[k]++;
            if (age[k] == lat) begin
                m_resp[k] = 1'b1;
                ew[k] = mw[k];
                if (mw[k]) begin
                    shadow[k][ma[k]] = md[k];
                    ed[k] = 8'h00;
                end else begin
                    ed[k] = shadow[k][ma[k]];
                end
            end
        end else if (rr) begin
            m_pend[k] = 1'b0;
            m_resp[k] = 1'b0;
            ed[k] = 8'h00;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_pend[k] = 1'b0;
                m_resp[k] = 1'b0;
                ed[k] = 8'h00;
                ew[k] = 1'b0;
            end
        end else begin
            model_step(0, LAT0, req_valid, req_addr, req_data, req_w_r, rsp_ready);
            model_step(1, LAT1, req_valid1, req_addr1, req_data1, req_w_r1, rsp_ready1);
        end
    end

    always @(negedge clk) begin
        check("req_ready0", 32'(req_ready), 32'(!m_pend[0]));
        check("busy0",      32'(busy),      32'(m_pend[0]));
        check("rsp_valid0", 32'(rsp_valid), 32'(m_resp[0]));
        check("rsp_data0",  32'(rsp_data),  32'(ed[0]));
        check("rsp_w_r0",   32'(rsp_w_r),   32'(ew[0]));
        check("req_ready1", 32'(req_ready1), 32'(!m_pend[1]));
        check("busy1",      32'(busy1),      32'(m_pend[1]));
        check("rsp_valid1", 32'(rsp_valid1), 32'(m_resp[1]));
        check("rsp_data1",  32'(rsp_data1),  32'(ed[1]));
        check("rsp_w_r1",   32'(rsp_w_r1),   32'(ew[1]));
    end

    task automatic preload(input int k, input logic [7:0] a, input logic [7:0] v);
        if (k == 0) dut.mem[a] = v;
        else        dut1.mem[a] = v;
        shadow[k][a] = v;
    endtask

    // Single transaction on dut with rsp_ready=1; returns data, direction and
    // number of edges from accept to rsp_valid. Ends at the negedge after the
    // response has been consumed.
    task automatic do_txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                          output logic [7:0] rdata, output logic rw, output int lat);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_w_r   = w;
        rsp_ready = 1'b1;
        @(posedge clk);
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (rsp_valid) break;
            @(posedge clk);
            lat++;
        end
        if (lat >= 50) begin
            n_chk++;
            n_fail++;
            $display("FAIL txn_timeout: actual=no rsp_valid required=rsp_valid within 50 cycles");
        end
        rdata = rsp_data;
        rw    = rsp_w_r;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [7:0] t6_addr [4] = '{8'h50, 8'h51, 8'h52, 8'h53};
    logic [7:0] t6_data [4] = '{8'h61, 8'h72, 8'h83, 8'h94};

    initial begin
        logic [7:0] rd;
        logic       rw;
        int         lat;
        int         k;
        int         acc [4];
        int         nacc;
        int         nresp;
        logic       chg;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(rsp_data),  32'd0);
        check("rst_rsp_w_r",   32'(rsp_w_r),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);

        // 1: basic read
        preload(0, 8'h10, 8'hA5);
        do_txn(1'b0, 8'h10, 8'h00, rd, rw, lat);
        check("t1_data", 32'(rd), 32'hA5);
        check("t1_w_r",  32'(rw), 32'd0);
        check("t1_lat",  lat, 32'd3);

        // 2: write then read back
        do_txn(1'b1, 8'h22, 8'h3C, rd, rw, lat);
        check("t2_wack_data", 32'(rd), 32'h00);
        check("t2_wack_w_r",  32'(rw), 32'd1);
        do_txn(1'b0, 8'h22, 8'h00, rd, rw, lat);
        check("t2_rd_data", 32'(rd), 32'h3C);
        check("t2_rd_w_r",  32'(rw), 32'd0);

        // 3: backpressure with noisy request inputs
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 8'h10;
        req_w_r   = 1'b0;
        rsp_ready = 1'b0;
        @(posedge clk);
        k = 0;
        while (k < 50) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (rsp_valid) break;
            @(posedge clk);
            k++;
        end
        check("t3_lat", k, 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(rsp_valid), 32'd1);
            check("t3_hold_data",  32'(rsp_data),  32'hA5);
            check("t3_no_accept",  32'(req_ready), 32'd0);
            req_valid = ~req_valid;
            req_addr  = 8'(i * 17 + 3);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t3_idle_ready", 32'(req_ready), 32'd1);
        check("t3_idle_valid", 32'(rsp_valid), 32'd0);
        check("t3_idle_data",  32'(rsp_data),  32'd0);

        // 4: reset two cycles into WAIT of a write
        preload(0, 8'h40, 8'h11);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 8'h40;
        req_data  = 8'h77;
        req_w_r   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t4_busy_pre", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t4_rst_req_ready", 32'(req_ready), 32'd1);
        check("t4_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t4_rst_rsp_data",  32'(rsp_data),  32'd0);
        check("t4_rst_rsp_w_r",   32'(rsp_w_r),   32'd0);
        check("t4_rst_busy",      32'(busy),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_txn(1'b0, 8'h40, 8'h00, rd, rw, lat);
        check("t4_rd_data", 32'(rd), 32'h11);

        // 5: LATENCY=1 instance
        preload(1, 8'hFF, 8'h5E);
        @(negedge clk);
        req_valid1 = 1'b1;
        req_addr1  = 8'hFF;
        req_w_r1   = 1'b0;
        rsp_ready1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid1 = 1'b0;
        check("t5_not_yet", 32'(rsp_valid1), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("t5_valid", 32'(rsp_valid1), 32'd1);
        check("t5_data",  32'(rsp_data1),  32'h5E);
        @(posedge clk);
        @(negedge clk);
        check("t5_idle", 32'(req_ready1), 32'd1);

        // 6: back-to-back with req_valid held high
        for (int i = 0; i < 4; i++) preload(0, t6_addr[i], t6_data[i]);
        nacc  = 0;
        nresp = 0;
        chg   = 1'b0;
        @(negedge clk);
        req_addr  = t6_addr[0];
        req_w_r   = 1'b0;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 60 && nresp < 4; c++) begin
            if (c > 0) @(negedge clk);
            if (chg) begin
                chg = 1'b0;
                if (nacc < 4) req_addr = t6_addr[nacc];
                else          req_valid = 1'b0;
            end
            if (rsp_valid) begin
                if (nresp < 4) check("t6_order_data", 32'(rsp_data), 32'(t6_data[nresp]));
                nresp++;
            end
            if (req_valid && req_ready && nacc < 4) begin
                acc[nacc] = c;
                nacc++;
                chg = 1'b1;
            end
        end
        req_valid = 1'b0;
        check("t6_accepts",   nacc,  32'd4);
        check("t6_responses", nresp, 32'd4);
        for (int i = 0; i < 3; i++) begin
            if (i + 1 < nacc) check("t6_spacing", acc[i+1] - acc[i], 32'd5);
        end
        @(posedge clk);
        @(negedge clk);
        check("t6_final_idle", 32'(req_ready), 32'd1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=simulation still running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
